// File: rtl/fifo_pkg.sv
// Shared FIFO definitions used by both the read-side and write-side pointer blocks.
package fifo_pkg;

    // Default geometry of the FIFO memory.
    localparam int DATASIZE_DEF = 8;
    localparam int ADDRSIZE_DEF = 4;

    // Pointer width: one extra MSB beyond the address distinguishes laps.
    localparam int PTR_W = ADDRSIZE_DEF + 1;

    // Widest pointer bin2gray handles; narrower pointers are zero-extended
    // and the low bits of the result taken.
    localparam int PTR_MAX = 32;

    // Binary to reflected Gray code conversion.
    function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order buffer sitting between the FIFO memory read port and the
// output stream. Head entry is always slot e0 so dout comes straight from a flop.
module fifo_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       cnt
);

    logic [WIDTH-1:0] e0;
    logic [WIDTH-1:0] e1;
    logic [1:0]       cnt_q;

    // Entry shuffling: a pop shifts e1 into e0, a push lands behind whatever survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            e0    <= '0;
            e1    <= '0;
            cnt_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) e0 <= din;
                    else               e1 <= din;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    e0    <= e1;
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        e0 <= e1;
                        e1 <= din;
                    end else begin
                        e0 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout = e0;
    assign cnt  = cnt_q;

endmodule

// File: rtl/fifo_rd_prefetch.sv
// Read side of an async FIFO with a two-word prefetch buffer that turns the
// memory read port into a registered valid/ready stream.
//
// Stream handshake: a word transfers on every rclk edge where m_valid and
// m_ready are both 1. m_valid never drops and m_data never changes while a
// word is offered and not yet taken; m_valid does not depend on m_ready.
module fifo_rd_prefetch
    import fifo_pkg::*;
#(
    parameter int DATASIZE = DATASIZE_DEF,
    parameter int ADDRSIZE = ADDRSIZE_DEF
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] raddr,
    input  logic [DATASIZE-1:0] rdata,
    output logic                rempty,
    output logic [DATASIZE-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [1:0]          buf_cnt
);

    logic [ADDRSIZE:0]  rbin;
    logic [ADDRSIZE:0]  rbin_next;
    logic [ADDRSIZE:0]  gray_next;
    logic [PTR_MAX-1:0] gray_full;
    logic [1:0]         cnt_after;
    logic               take;
    logic               rinc;

    // Fetch a word only if it is there and the buffer will have room after this edge's take.
    always_comb begin
        take      = m_valid & m_ready;
        cnt_after = buf_cnt - {1'b0, take};
        rinc      = !rempty && (cnt_after < 2'd2);
        rbin_next = rbin + {{ADDRSIZE{1'b0}}, rinc};
        gray_full = bin2gray({{(PTR_MAX-ADDRSIZE-1){1'b0}}, rbin_next});
        gray_next = gray_full[ADDRSIZE:0];
    end

    // Pointer and empty flag registers; empty compares the look-ahead Gray pointer.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
        end else begin
            rbin   <= rbin_next;
            rptr   <= gray_next;
            rempty <= (gray_next == rq2_wptr);
        end
    end

    assign raddr   = rbin[ADDRSIZE-1:0];
    assign m_valid = (buf_cnt != 2'd0);

    fifo_skid_buf #(
        .WIDTH (DATASIZE)
    ) u_skid_buf (
        .clk  (rclk),
        .rst  (rrst),
        .push (rinc),
        .pop  (take),
        .din  (rdata),
        .dout (m_data),
        .cnt  (buf_cnt)
    );

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Directed + randomized bench for fifo_rd_prefetch against a word-count model.
module tb_fifo_rd_prefetch;

    logic       rclk;
    logic       rrst;
    logic [4:0] rq2_wptr;
    logic [4:0] rptr;
    logic [3:0] raddr;
    logic [7:0] rdata;
    logic       rempty;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [1:0] buf_cnt;

    // Clock/reset block
    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // Behavioural memory with combinational read
    logic [7:0] mem [16];
    assign rdata = mem[raddr];

    fifo_rd_prefetch #(.DATASIZE(8), .ADDRSIZE(4)) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .rq2_wptr (rq2_wptr),
        .rptr     (rptr),
        .raddr    (raddr),
        .rdata    (rdata),
        .rempty   (rempty),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .buf_cnt  (buf_cnt)
    );

    // Reference model: counts of words written, fetched from memory, delivered
    int         nvec = 0;
    int         nerr = 0;
    int         written;
    int         fetched;
    int         delivered;
    bit         mempty;
    logic [7:0] exp_q [$];   // every word written since reset, in order
    bit         seen_31;
    bit         seen_wrap;

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] v;
        v = 5'(b % 32);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver: writer side puts a word in memory and publishes the new write pointer
    task automatic write_word(input logic [7:0] d);
        mem[written % 16] = d;
        exp_q.push_back(d);
        written++;
        rq2_wptr = gray5(written);
    endtask

    // One clock: advance the model with the current inputs, then check outputs
    task automatic cycle();
        int   cnt;
        bit   take;
        bit   rinc;
        logic pre_rempty;
        logic [4:0] pre_rptr;
        logic pre_hold;
        logic [7:0] pre_data;
        cnt        = fetched - delivered;
        take       = (cnt > 0) && m_ready;
        rinc       = !mempty && ((cnt - int'(take)) < 2);
        pre_rempty = rempty;
        pre_rptr   = rptr;
        pre_hold   = m_valid && !m_ready;
        pre_data   = m_data;
        if (take) delivered++;
        if (rinc) fetched++;
        mempty = (fetched == written);
        @(posedge rclk);
        #1;
        chk("rempty",  32'(rempty),  32'(mempty));
        chk("buf_cnt", 32'(buf_cnt), 32'(fetched - delivered));
        chk("m_valid", 32'(m_valid), 32'(fetched != delivered));
        chk("rptr",    32'(rptr),    32'(gray5(fetched)));
        chk("raddr",   32'(raddr),   32'(fetched % 16));
        if (fetched != delivered)
            chk("m_data", 32'(m_data), 32'(exp_q[delivered]));
        if (pre_rempty === 1'b1)
            chk("no_read_when_empty", 32'(rptr), 32'(pre_rptr));
        if (pre_hold === 1'b1) begin
            chk("hold_valid", 32'(m_valid), 32'd1);
            chk("hold_data",  32'(m_data),  32'(pre_data));
        end
        if (pre_rptr == gray5(31) && rptr == gray5(0)) seen_wrap = 1'b1;
        if (rptr == gray5(31)) seen_31 = 1'b1;
    endtask

    task automatic do_reset();
        rrst     = 1'b1;
        written  = 0;
        rq2_wptr = '0;
        exp_q.delete();
        @(posedge rclk);
        #1;
        rrst      = 1'b0;
        fetched   = 0;
        delivered = 0;
        mempty    = 1'b1;
        chk("rst_rptr",    32'(rptr),    32'd0);
        chk("rst_rempty",  32'(rempty),  32'd1);
        chk("rst_buf_cnt", 32'(buf_cnt), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data",  32'(m_data),  32'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        rrst = 1'b1; rq2_wptr = '0; m_ready = 1'b0;
        written = 0; fetched = 0; delivered = 0; mempty = 1'b1;
        seen_31 = 1'b0; seen_wrap = 1'b0;
        repeat (2) @(posedge rclk);
        #1;

        // Step 1: single word latency
        do_reset();
        write_word(8'hA5);
        cycle();
        chk("lat_rempty_fall", 32'(rempty), 32'd0);
        cycle();
        chk("lat_m_valid", 32'(m_valid), 32'd1);
        chk("lat_m_data",  32'(m_data),  32'hA5);
        chk("lat_rptr",    32'(rptr),    32'(5'b00001));
        m_ready = 1'b1;
        cycle();
        cycle();

        // Step 2: fill 16 words with consumer stalled, then release
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            write_word(8'(i));
            cycle();
        end
        repeat (2) cycle();
        chk("fill_buf_cnt", 32'(buf_cnt), 32'd2);
        chk("fill_rptr",    32'(rptr),    32'(5'b00011));
        chk("fill_m_data",  32'(m_data),  32'h00);
        m_ready = 1'b1;
        n = 0;
        while (delivered < 16 && n < 40) begin
            cycle();
            n++;
        end
        chk("drain_cycles", 32'(n), 32'd16);
        chk("drain_rempty", 32'(rempty), 32'd1);
        chk("drain_valid",  32'(m_valid), 32'd0);

        // Step 3: stream 40 words through the pointer wrap
        do_reset();
        m_ready = 1'b1;
        seen_31 = 1'b0; seen_wrap = 1'b0;
        n = 0;
        while (delivered < 40 && n < 200) begin
            if (written < 40 && (written - fetched) < 16)
                write_word(8'($urandom_range(0, 255)));
            cycle();
            n++;
        end
        chk("wrap_delivered", 32'(delivered), 32'd40);
        chk("wrap_seen_31",   32'(seen_31),   32'd1);
        chk("wrap_seen_0",    32'(seen_wrap), 32'd1);

        // Step 4: random consumer with a bursty writer
        do_reset();
        for (int i = 0; i < 400; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 7 && (written - fetched) < 16)
                write_word(8'($urandom_range(0, 255)));
            cycle();
        end

        // Step 5: reset while the buffer is full
        m_ready = 1'b0;
        n = 0;
        while ((fetched - delivered) < 2 && n < 20) begin
            if ((written - fetched) < 16)
                write_word(8'($urandom_range(0, 255)));
            cycle();
            n++;
        end
        chk("pre_rst_buf_cnt", 32'(buf_cnt), 32'd2);
        do_reset();
        chk("post_rst_valid",  32'(m_valid), 32'd0);
        chk("post_rst_rptr",   32'(rptr),    32'd0);
        chk("post_rst_rempty", 32'(rempty),  32'd1);
        m_ready = 1'b1;
        write_word(8'h3C);
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fifo_rd_prefetch.md
FIFO_RD_PREFETCH -- requirements
Module: fifo_rd_prefetch

Interface
REQ-001 The block SHALL have parameter DATASIZE, default 8, data word width.
REQ-002 The block SHALL have parameter ADDRSIZE, default 4, memory address bits; depth = 2**ADDRSIZE.
REQ-003 The block SHALL have port rclk, input, 1, the single read-domain clock.
REQ-004 The block SHALL have port rrst, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port rq2_wptr, input, ADDRSIZE+1, Gray write pointer already synchronized into rclk.
REQ-006 The block SHALL have port rptr, output, ADDRSIZE+1, registered Gray read pointer returned to the write side.
REQ-007 The block SHALL have port raddr, output, ADDRSIZE, read address to the dual-port memory.
REQ-008 The block SHALL have port rdata, input, DATASIZE, combinational memory read data for raddr.
REQ-009 The block SHALL have port rempty, output, 1, registered memory-empty flag.
REQ-010 The block SHALL have port m_data, output, DATASIZE, stream data.
REQ-011 The block SHALL have port m_valid, output, 1, stream valid.
REQ-012 The block SHALL have port m_ready, input, 1, stream ready from the consumer.
REQ-013 The block SHALL have port buf_cnt, output, 2, occupancy of the prefetch buffer (0..2).

Function
REQ-014 rbin (ADDRSIZE+1 bits) SHALL be the binary read pointer; raddr = rbin[ADDRSIZE-1:0]; rptr SHALL register bin2gray(rbin_next).
REQ-015 take = m_valid & m_ready; rinc = !rempty & ((buf_cnt - take) < 2); rbin_next = rbin + rinc.
REQ-016 rempty SHALL register (bin2gray(rbin_next) == rq2_wptr).
REQ-017 On rinc, rdata SHALL be captured into the buffer slot after the surviving entries at the same edge.
REQ-018 m_valid = (buf_cnt != 0); m_data SHALL be the head entry, driven from a register.
REQ-019 On take, the head SHALL retire and the second entry, if any, becomes the head.
REQ-020 For simultaneous take and rinc, buf_cnt SHALL be unchanged and ordering preserved.
REQ-021 m_data SHALL remain stable while m_valid=1 and m_ready=0.
REQ-022 Latency: if rq2_wptr becomes non-empty at edge N, then rempty=0 after N+1, rinc at N+1, and m_valid=1 after N+2.
REQ-023 With m_ready held high and data available, throughput SHALL be one word per cycle with no bubbles.
REQ-024 The pointer SHALL wrap modulo 2**(ADDRSIZE+1), with the MSB distinguishing laps.
REQ-025 The memory SHALL never be read while rempty=1.
REQ-026 The buffer SHALL never exceed 2 entries, and no word SHALL be dropped or duplicated.

Reset
REQ-027 While rrst=1 at an rclk edge: rbin=0, rptr=0, rempty=1, buf_cnt=0, m_valid=0, m_data=0.
REQ-028 Mid-operation reset SHALL discard buffered words; the first cycle after reset SHALL behave as the post-reset state.

Structure
REQ-029 Function bin2gray and the pointer-width constant SHALL live in shared package fifo_pkg, also used by the write-side block.
REQ-030 The two-entry buffer SHALL be sub-module fifo_skid_buf (inputs: push, pop, din; outputs: dout, cnt), instantiated once.

Verification
REQ-031 Reset, then rq2_wptr=gray(1) with memory[0]=0xA5 -> rempty falls after 1 cycle; m_valid=1 and m_data=0xA5 after 2 cycles; rptr=gray(1).
REQ-032 Fill 16 words (0x00..0x0F), m_ready=0 -> buf_cnt=2, rbin=2, m_data=0x00 stable; release m_ready -> 0x00..0x0F on consecutive cycles, then rempty=1 and m_valid=0.
REQ-033 Wrap: stream 40 words with ADDRSIZE=4 -> output order exact; rptr traverses gray(31)->gray(0); no read while rempty=1.
REQ-034 Random m_ready with continuous writer -> scoreboard matches, buf_cnt<=2, no hold violation.
REQ-035 Assert rrst for 1 cycle while buf_cnt=2 -> next cycle m_valid=0, rptr=0, rempty=1.
